// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned MEM_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_t;

  // Access held on the memory pins for the whole latency window
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_acc_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory macro pins of the unified-memory arbiter.
interface mem_arbiter_if;

  logic                                i_req;
  logic [mem_arbiter_pkg::ADDR_W-1:0]  i_addr;
  logic                                i_flush;
  logic [mem_arbiter_pkg::DATA_W-1:0]  i_rdata;
  logic                                i_done;
  logic                                i_stall;

  logic                                d_req;
  logic                                d_we;
  logic [mem_arbiter_pkg::ADDR_W-1:0]  d_addr;
  logic [mem_arbiter_pkg::DATA_W-1:0]  d_wdata;
  logic [mem_arbiter_pkg::DATA_W-1:0]  d_rdata;
  logic                                d_done;
  logic                                d_stall;

  logic                                mem_en;
  logic                                mem_we;
  logic [mem_arbiter_pkg::ADDR_W-1:0]  mem_addr;
  logic [mem_arbiter_pkg::DATA_W-1:0]  mem_wdata;
  logic [mem_arbiter_pkg::DATA_W-1:0]  mem_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, i_flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output i_rdata, i_done, i_stall,
    output d_rdata, d_done, d_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // CPU pipeline and memory macro side
  modport master (
    output i_req, i_addr, i_flush,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  i_rdata, i_done, i_stall,
    input  d_rdata, d_done, d_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency single-ported memory,
// with one-slot aging so a busy data port cannot starve fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        r_state,   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic              r_aged,    w_aged_nxt;
  logic              r_flushed, w_flushed_nxt;
  logic              r_mem_en,  w_mem_en_nxt;
  mem_acc_t          r_acc,     w_acc_nxt;
  logic [DATA_W-1:0] r_i_rdata, w_i_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
  logic              r_i_done,  w_i_done_nxt;
  logic              r_d_done,  w_d_done_nxt;

  logic w_d_grant;
  logic w_i_grant;
  logic w_last;

  // Data wins unless fetch is also waiting and was already passed over once
  assign w_d_grant = bus.d_req & (~bus.i_req | ~r_aged);
  assign w_i_grant = bus.i_req & ~bus.i_flush;
  assign w_last    = (r_cnt == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_aged    <= 1'b0;
      r_flushed <= 1'b0;
      r_mem_en  <= 1'b0;
      r_acc     <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_aged    <= w_aged_nxt;
      r_flushed <= w_flushed_nxt;
      r_mem_en  <= w_mem_en_nxt;
      r_acc     <= w_acc_nxt;
      r_i_rdata <= w_i_rdata_nxt;
      r_d_rdata <= w_d_rdata_nxt;
      r_i_done  <= w_i_done_nxt;
      r_d_done  <= w_d_done_nxt;
    end
  end

  // Grant, latency countdown and completion
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_aged_nxt    = r_aged;
    w_flushed_nxt = r_flushed;
    w_mem_en_nxt  = r_mem_en;
    w_acc_nxt     = r_acc;
    w_i_rdata_nxt = r_i_rdata;
    w_d_rdata_nxt = r_d_rdata;
    w_i_done_nxt  = 1'b0;
    w_d_done_nxt  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_d_grant) begin
          w_state_nxt     = D_ACC;
          w_cnt_nxt       = CNT_LOAD;
          w_mem_en_nxt    = 1'b1;
          w_acc_nxt.we    = bus.d_we;
          w_acc_nxt.addr  = bus.d_addr;
          w_acc_nxt.wdata = bus.d_wdata;
          if (bus.i_req) begin
            w_aged_nxt = 1'b1;
          end
        end else if (w_i_grant) begin
          w_state_nxt    = I_ACC;
          w_cnt_nxt      = CNT_LOAD;
          w_mem_en_nxt   = 1'b1;
          w_acc_nxt.we   = 1'b0;
          w_acc_nxt.addr = bus.i_addr;
          w_aged_nxt     = 1'b0;
          w_flushed_nxt  = 1'b0;
        end
      end

      I_ACC: begin
        if (bus.i_flush) begin
          w_flushed_nxt = 1'b1;
        end
        if (w_last) begin
          w_state_nxt  = IDLE;
          w_mem_en_nxt = 1'b0;
          w_acc_nxt.we = 1'b0;
          // A squashed fetch still occupies the memory but reports nothing
          if (!(r_flushed || bus.i_flush)) begin
            w_i_done_nxt  = 1'b1;
            w_i_rdata_nxt = bus.mem_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      D_ACC: begin
        if (w_last) begin
          w_state_nxt  = IDLE;
          w_mem_en_nxt = 1'b0;
          w_acc_nxt.we = 1'b0;
          w_d_done_nxt = 1'b1;
          if (!r_acc.we) begin
            w_d_rdata_nxt = bus.mem_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_mem_en_nxt = 1'b0;
        w_acc_nxt.we = 1'b0;
      end
    endcase
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_acc.we;
  assign bus.mem_addr  = r_acc.addr;
  assign bus.mem_wdata = r_acc.wdata;

  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_done    = r_i_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_done    = r_d_done;

  // Pipeline freeze terms, combinational from the live request
  assign bus.i_stall   = bus.i_req & ~r_i_done;
  assign bus.d_stall   = bus.d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level
// arbitration model and a reference memory image.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  // Reference model state
  bit                m_aged;
  logic [DATA_W-1:0] exp_i_rdata;
  logic [DATA_W-1:0] exp_d_rdata;
  logic [DATA_W-1:0] sim_mem [256];
  logic [DATA_W-1:0] ref_mem [256];

  // Round configuration
  bit                c_ri, c_rd, c_rd2, c_dwe;
  logic [ADDR_W-1:0] c_ia, c_da, c_da2;
  logic [DATA_W-1:0] c_dwd;

  mem_arbiter_if bus ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.MEM_LAT(LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro: read data follows the address, writes land while strobed
  assign bus.mem_rdata  = sim_mem[bus.mem_addr[7:0]];
  assign bus1.mem_rdata = sim_mem[bus1.mem_addr[7:0]];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) sim_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    sim_mem[a[7:0]] <= v;
    ref_mem[a[7:0]] = v;
  endtask

  // One round: both ports may request, data may re-request on its done cycle
  task automatic run_round();
    bit                pi, pd, d2, win_d, ewe;
    int                n, t;
    logic [ADDR_W-1:0] eaddr;
    logic [DATA_W-1:0] ewd;
    pi = c_ri; pd = c_rd; d2 = c_rd2;
    @(negedge clk);
    bus.i_req = pi; bus.i_addr = c_ia; bus.i_flush = 1'b0;
    bus.d_req = pd; bus.d_we = c_dwe; bus.d_addr = c_da; bus.d_wdata = c_dwd;
    #1;
    chk("i_stall_req", 32'(bus.i_stall), 32'(pi));
    chk("d_stall_req", 32'(bus.d_stall), 32'(pd));
    n = 0;
    t = LAT + 1;
    while (pi || pd) begin
      win_d = pd && (!pi || !m_aged);
      if (win_d) begin
        if (pi) m_aged = 1'b1;
        eaddr = bus.d_addr; ewe = bus.d_we; ewd = bus.d_wdata;
      end else begin
        m_aged = 1'b0;
        eaddr = bus.i_addr; ewe = 1'b0; ewd = '0;
      end
      while (n < t) begin
        @(negedge clk);
        n++;
        chk("mem_en", 32'(bus.mem_en), 32'(n >= t - LAT && n < t));
        if (n < t) begin
          chk("i_done_early", 32'(bus.i_done), 32'(0));
          chk("d_done_early", 32'(bus.d_done), 32'(0));
          chk("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
          chk("mem_we", 32'(bus.mem_we), 32'(ewe));
          if (ewe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(ewd));
          chk("i_stall_wait", 32'(bus.i_stall), 32'(pi));
        end
      end
      if (win_d) begin
        chk("d_done", 32'(bus.d_done), 32'(1));
        chk("i_done_other", 32'(bus.i_done), 32'(0));
        if (ewe) ref_mem[eaddr[7:0]] = ewd;
        else     exp_d_rdata = ref_mem[eaddr[7:0]];
        chk("d_rdata", 32'(bus.d_rdata), 32'(exp_d_rdata));
        chk("d_stall_done", 32'(bus.d_stall), 32'(0));
        pd = 1'b0;
        bus.d_req = 1'b0;
        if (d2) begin
          d2 = 1'b0; pd = 1'b1;
          bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = c_da2;
        end
      end else begin
        chk("i_done", 32'(bus.i_done), 32'(1));
        chk("d_done_other", 32'(bus.d_done), 32'(0));
        exp_i_rdata = ref_mem[eaddr[7:0]];
        chk("i_rdata", 32'(bus.i_rdata), 32'(exp_i_rdata));
        chk("i_stall_done", 32'(bus.i_stall), 32'(0));
        pi = 1'b0;
        bus.i_req = 1'b0;
      end
      t += LAT + 1;
    end
  endtask

  // Single access already requested: LAT busy cycles, then the done cycle
  task automatic expect_access(input bit is_d, input logic [ADDR_W-1:0] a);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("acc_mem_en", 32'(bus.mem_en), 32'(1));
      chk("acc_mem_addr", 32'(bus.mem_addr), 32'(a));
    end
    @(negedge clk);
    chk("acc_mem_en_off", 32'(bus.mem_en), 32'(0));
    if (is_d) begin
      exp_d_rdata = ref_mem[a[7:0]];
      chk("acc_d_done", 32'(bus.d_done), 32'(1));
      chk("acc_d_rdata", 32'(bus.d_rdata), 32'(exp_d_rdata));
      bus.d_req = 1'b0;
    end else begin
      exp_i_rdata = ref_mem[a[7:0]];
      m_aged = 1'b0;
      chk("acc_i_done", 32'(bus.i_done), 32'(1));
      chk("acc_i_rdata", 32'(bus.i_rdata), 32'(exp_i_rdata));
      bus.i_req = 1'b0;
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a1;
    n_run = 0; n_fail = 0;
    m_aged = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.i_flush = 1'b0;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    for (int i = 0; i < 256; i++) preload(ADDR_W'(i), DATA_W'($urandom));
    #1;
    chk("rst_mem_en", 32'(bus.mem_en), 32'(0));
    chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("rst_i_rdata", 32'(bus.i_rdata), 32'(0));
    chk("rst_d_done", 32'(bus.d_done), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single fetch
    preload(16'h0010, 16'hB123);
    c_ri = 1; c_rd = 0; c_rd2 = 0; c_ia = 16'h0010;
    run_round();

    // Simultaneous requests: data first, then aged fetch beats the re-issued load
    preload(16'h8000, 16'h7E57);
    c_ri = 1; c_rd = 1; c_rd2 = 1; c_dwe = 0;
    c_ia = 16'h0020; c_da = 16'h8000; c_da2 = 16'h0030;
    run_round();

    // Store, then read it back
    c_ri = 0; c_rd = 1; c_rd2 = 0; c_dwe = 1; c_da = 16'h0200; c_dwd = 16'h5A5A;
    run_round();
    c_dwe = 0;
    run_round();

    // Flush during the second cycle of a fetch, redirected fetch follows
    preload(16'h0040, 16'h1111);
    preload(16'h0044, 16'h2222);
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 16'h0040;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("fl_mem_en", 32'(bus.mem_en), 32'(1));
      chk("fl_mem_addr", 32'(bus.mem_addr), 32'h0040);
      chk("fl_i_done", 32'(bus.i_done), 32'(0));
      bus.i_flush = (k == 2);
      if (k == 2) bus.i_addr = 16'h0044;
    end
    @(negedge clk);
    chk("fl_no_done", 32'(bus.i_done), 32'(0));
    chk("fl_rdata_held", 32'(bus.i_rdata), 32'(exp_i_rdata));
    chk("fl_stall", 32'(bus.i_stall), 32'(1));
    chk("fl_mem_en_off", 32'(bus.mem_en), 32'(0));
    expect_access(1'b0, 16'h0044);

    // Flush in IDLE blocks that cycle's fetch grant
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 16'h0048; bus.i_flush = 1'b1;
    @(negedge clk);
    chk("fl_idle_blocked", 32'(bus.mem_en), 32'(0));
    bus.i_flush = 1'b0;
    expect_access(1'b0, 16'h0048);

    // Reset during the second cycle of a load; request stays pending
    preload(16'h0080, 16'h3333);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0080;
    repeat (2) @(negedge clk);
    chk("pre_rst_mem_en", 32'(bus.mem_en), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_en", 32'(bus.mem_en), 32'(0));
    chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("mid_rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
    chk("mid_rst_i_rdata", 32'(bus.i_rdata), 32'(0));
    chk("mid_rst_d_rdata", 32'(bus.d_rdata), 32'(0));
    chk("mid_rst_d_done", 32'(bus.d_done), 32'(0));
    exp_i_rdata = '0; exp_d_rdata = '0; m_aged = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_access(1'b1, 16'h0080);

    // Randomized rounds
    for (int r = 0; r < 24; r++) begin
      c_ri  = 1'($urandom_range(0, 1));
      c_rd  = 1'($urandom_range(0, 1));
      if (!c_ri && !c_rd) c_rd = 1'b1;
      c_rd2 = c_rd && 1'($urandom_range(0, 1));
      c_dwe = 1'($urandom_range(0, 1));
      c_ia  = ADDR_W'($urandom); c_da = ADDR_W'($urandom); c_da2 = ADDR_W'($urandom);
      c_dwd = DATA_W'($urandom);
      run_round();
    end

    // MEM_LAT = 1: held fetch request completes every second cycle
    @(negedge clk);
    a1 = 16'h0010;
    bus1.i_req = 1'b1; bus1.i_addr = a1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("l1_mem_en", 32'(bus1.mem_en), 32'(1));
      chk("l1_mem_addr", 32'(bus1.mem_addr), 32'(a1));
      chk("l1_no_done", 32'(bus1.i_done), 32'(0));
      @(negedge clk);
      chk("l1_done", 32'(bus1.i_done), 32'(1));
      chk("l1_rdata", 32'(bus1.i_rdata), 32'(ref_mem[a1[7:0]]));
      chk("l1_mem_en_off", 32'(bus1.mem_en), 32'(0));
      a1 = a1 + 16'h0001;
      bus1.i_addr = a1;
      if (j == 2) bus1.i_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
